// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
module md_unit #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clka,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;   // product / quotient sign
  logic             neg_rem_q, neg_rem_d;   // remainder follows dividend sign
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;         // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;     // partial product high / remainder
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;     // multiplier / dividend-quotient shifter
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh, div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Operand magnitudes and per-iteration datapath terms
  always_comb begin
    a_neg    = ~op[0] & a[WIDTH-1];
    b_neg    = ~op[0] & b[WIDTH-1];
    abs_a    = a_neg ? -a : a;
    abs_b    = b_neg ? -b : b;
    mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, opnd_q};
    prod     = {acc_hi_q, acc_lo_q};
    prod_fix = neg_res_q ? -prod : prod;
    quo_fix  = neg_res_q ? -acc_lo_q : acc_lo_q;
    rem_fix  = neg_rem_q ? -acc_hi_q : acc_hi_q;
  end

  // Next-state and datapath update for IDLE / RUN / FIX
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    opnd_d     = opnd_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          state_d   = S_RUN;
          cnt_d     = '0;
          is_div_d  = op[1];
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dz_d      = op[1] && (b == '0);
          acc_hi_d  = '0;
          opnd_d    = op[1] ? abs_b : abs_a;
          acc_lo_d  = op[1] ? abs_a : abs_b;
        end else if (!start) begin
          if (wr_hi) hi_d = wdata;
          if (wr_lo) lo_d = wdata;
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          if (is_div_q) begin
            // Restoring step: keep the trial subtraction only if it did not borrow
            if (!div_diff[WIDTH]) begin
              acc_hi_d = div_diff[WIDTH-1:0];
              acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi_d = div_sh[WIDTH-1:0];
              acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            // Shift-add step: carry out of the add re-enters at the top
            acc_hi_d = mul_sum[WIDTH:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        if (!flush) begin
          done_d = 1'b1;
          if (dz_q) begin
            div_zero_d = 1'b1;
          end else if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      opnd_q     <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      opnd_q     <= opnd_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - directed vector bench for md_unit
module tb_md_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        flush, wr_hi, wr_lo;
  logic [31:0] wdata;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  md_unit #(.WIDTH(32)) dut (
    .clka(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    logic        mid;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Launch one op and observe a fixed 40-cycle window after the start edge.
  task automatic run_op(input logic [1:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                        input logic mid, output int busy_cyc, output int done_cnt,
                        output int done_idx, output int dz_cnt);
    @(negedge clk);
    start = 1'b1; op = op_v; a = a_v; b = b_v;
    @(posedge clk); #1;
    start = 1'b0;
    busy_cyc = 0; done_cnt = 0; done_idx = -1; dz_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_cyc++;
      if (done) begin done_cnt++; done_idx = i; end
      if (div_zero) dz_cnt++;
      if (mid && i == 10) begin start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd3; end
      if (mid && i == 11) start = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int bc, dc, di, zc;
    vecs[0] = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0};
    vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b1};
    vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0};
    vecs[3] = '{2'b11, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, 1'b0};
    vecs[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0};
    vecs[5] = '{2'b00, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, 1'b0, 1'b0};
    vecs[6] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0};
    vecs[7] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0};

    rst = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    flush = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
    #22;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk); rst = 1'b1;

    // Table-driven operations
    for (int k = 0; k < 8; k++) begin
      run_op(vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].mid, bc, dc, di, zc);
      check($sformatf("v%0d_hi", k), {32'd0, hi}, {32'd0, vecs[k].hi});
      check($sformatf("v%0d_lo", k), {32'd0, lo}, {32'd0, vecs[k].lo});
      check($sformatf("v%0d_busy_cycles", k), 64'(bc), 64'd33);
      check($sformatf("v%0d_done_count", k), 64'(dc), 64'd1);
      check($sformatf("v%0d_done_at", k), 64'(di), 64'd33);
      check($sformatf("v%0d_dz_count", k), 64'(zc), 64'(vecs[k].dz));
    end

    // MTHI/MTLO preload then divide by zero
    @(negedge clk); wr_hi = 1'b1; wdata = 32'h11111111;
    @(negedge clk); wr_hi = 1'b0; wr_lo = 1'b1; wdata = 32'h22222222;
    @(negedge clk); wr_lo = 1'b0;
    check("preload", {hi, lo}, 64'h11111111_22222222);
    run_op(2'b11, 32'd55, 32'd0, 1'b0, bc, dc, di, zc);
    check("dz_hilo", {hi, lo}, 64'h11111111_22222222);
    check("dz_busy_cycles", 64'(bc), 64'd33);
    check("dz_done_count", 64'(dc), 64'd1);
    check("dz_flag_count", 64'(zc), 64'd1);
    check("dz_done_at", 64'(di), 64'd33);

    // Flush on cycle 10; an MTHI while busy must be ignored
    @(negedge clk); start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
    @(posedge clk); #1; start = 1'b0;
    zc = 0;
    for (int i = 1; i < 10; i++) begin
      if (i == 5) begin wr_hi = 1'b1; wdata = 32'hDEADBEEF; end
      if (i == 6) wr_hi = 1'b0;
      @(posedge clk); #1;
      if (done) zc++;
    end
    check("flush_busy_before", {63'd0, busy}, 64'd1);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy_after", {63'd0, busy}, 64'd0);
    check("flush_done", 64'(zc) + {63'd0, done}, 64'd0);
    check("flush_hilo", {hi, lo}, 64'h11111111_22222222);
    run_op(2'b01, 32'd6, 32'd7, 1'b0, bc, dc, di, zc);
    check("after_flush_hilo", {hi, lo}, 64'd42);
    check("after_flush_done", 64'(dc), 64'd1);

    // Asynchronous reset mid-divide
    @(negedge clk); start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk); #1; rst = 1'b0;
    #1;
    check("arst_hilo", {hi, lo}, 64'd0);
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    @(negedge clk); rst = 1'b1;
    run_op(2'b11, 32'd100, 32'd7, 1'b0, bc, dc, di, zc);
    check("post_rst_hilo", {hi, lo}, 64'h00000002_0000000E);
    check("post_rst_busy_cycles", 64'(bc), 64'd33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
